// File: rtl/r2r_pkg.sv
// Shared constants and encodings for the R2R DAC wave sequencer.
//   DEPTH/IDX_W  : pattern memory depth and index width
//   DATA_W       : DAC code width
//   DIV_W        : sample-hold divider width
//   OP_*         : command opcodes carried on cmd_op
//   MODE_*       : playback order selected by CTRL[3:2]
//   state_t      : sequencer FSM states
package r2r_pkg;

   localparam int DEPTH  = 16;
   localparam int IDX_W  = 4;
   localparam int DATA_W = 4;
   localparam int DIV_W  = 8;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_LEN   = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_CTRL  = 2'd3;

   // Mode 2'b11 is not listed and falls through to one-shot behaviour.
   localparam logic [1:0] MODE_ONESHOT  = 2'd0;
   localparam logic [1:0] MODE_LOOP     = 2'd1;
   localparam logic [1:0] MODE_PINGPONG = 2'd2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

endpackage

// File: rtl/r2r_dac_wave_sequencer_if.sv
// Command port of the wave sequencer (valid/ready).
//   cmd_valid : command present (master -> slave)
//   cmd_ready : command accepted on a clk edge with cmd_valid (slave -> master)
//   cmd_op    : opcode, see r2r_pkg OP_*
//   cmd_arg   : opcode argument
interface r2r_dac_wave_sequencer_if;
   import r2r_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [DIV_W-1:0] cmd_arg;

   modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);

endinterface

// File: rtl/r2r_pattern_mem.sv
// 16x4 sample store: one synchronous write port, one asynchronous read port,
// cleared asynchronously on reset.
//   clk, n_rst        : clock, async active-high reset
//   we/wr_addr/wr_data: write port
//   rd_addr/rd_data   : combinational read port
module r2r_pattern_mem
   import r2r_pkg::*;
(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/r2r_dac_wave_sequencer.sv
// Pattern-playback controller for the 4-bit R2R DAC.
//   clk, n_rst  : clock, async active-high reset
//   cmd         : command port (slave side), WRITE/LEN/DIV/CTRL
//   r2r_out     : registered DAC code
//   sample_stb  : pulse in the cycle r2r_out takes a new sample
//   busy        : high while playing
//   done        : pulse on natural one-shot completion
//   idx         : index of the sample on r2r_out
//
// state | meaning
// IDLE  | waiting; all commands accepted, outputs hold last sample
// PLAY  | stepping samples every div+1 cycles; only CTRL accepted
module r2r_dac_wave_sequencer
   import r2r_pkg::*;
(
   input  logic                     clk,
   input  logic                     n_rst,
   r2r_dac_wave_sequencer_if.slave  cmd,
   output logic [DATA_W-1:0]        r2r_out,
   output logic                     sample_stb,
   output logic                     busy,
   output logic                     done,
   output logic [IDX_W-1:0]         idx
);

   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_PLAY = PLAY;

   logic [0:0]        state;
   logic [IDX_W-1:0]  len;
   logic [DIV_W-1:0]  div;
   logic [DIV_W-1:0]  tick;
   logic [1:0]        mode;
   logic              dir_down;

   logic              accept;
   logic              do_stop;
   logic              do_start;
   logic              mem_we;
   logic              finish;
   logic [IDX_W-1:0]  step_idx;
   logic              step_dir;
   logic [IDX_W-1:0]  rd_addr;
   logic [DATA_W-1:0] rd_data;

   always_comb begin
      cmd.cmd_ready = (state == ST_IDLE) || (cmd.cmd_op == OP_CTRL);
      accept   = cmd.cmd_valid && cmd.cmd_ready;
      do_stop  = accept && (cmd.cmd_op == OP_CTRL) && cmd.cmd_arg[1];
      do_start = accept && (cmd.cmd_op == OP_CTRL) && cmd.cmd_arg[0] && !cmd.cmd_arg[1];
      mem_we   = accept && (cmd.cmd_op == OP_WRITE);
   end

   // Next index/direction if the current sample expires this cycle.
   always_comb begin
      finish   = 1'b0;
      step_dir = dir_down;
      step_idx = idx + IDX_W'(1);
      case (mode)
         MODE_LOOP: begin
            if (idx == len) step_idx = '0;
         end
         MODE_PINGPONG: begin
            if (len == '0) begin
               step_idx = '0;
            end else if (!dir_down) begin
               if (idx == len) begin
                  step_dir = 1'b1;
                  step_idx = idx - IDX_W'(1);
               end
            end else begin
               if (idx == '0) step_dir = 1'b0;
               else           step_idx = idx - IDX_W'(1);
            end
         end
         default: begin
            finish = (idx == len);
         end
      endcase
   end

   // A start always loads entry 0, so the single read port serves both cases.
   assign rd_addr = do_start ? '0 : step_idx;

   r2r_pattern_mem u_mem (
      .clk     (clk),
      .n_rst   (n_rst),
      .we      (mem_we),
      .wr_addr (cmd.cmd_arg[7:4]),
      .wr_data (cmd.cmd_arg[3:0]),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state      <= ST_IDLE;
         len        <= '1;
         div        <= '0;
         tick       <= '0;
         mode       <= MODE_ONESHOT;
         dir_down   <= 1'b0;
         idx        <= '0;
         r2r_out    <= '0;
         sample_stb <= 1'b0;
         done       <= 1'b0;
      end else begin
         sample_stb <= 1'b0;
         done       <= 1'b0;

         if (accept && cmd.cmd_op == OP_LEN) len <= cmd.cmd_arg[IDX_W-1:0];
         if (accept && cmd.cmd_op == OP_DIV) div <= cmd.cmd_arg;

         if (do_stop) begin
            state <= ST_IDLE;
         end else if (do_start) begin
            state      <= ST_PLAY;
            mode       <= cmd.cmd_arg[3:2];
            idx        <= '0;
            r2r_out    <= rd_data;
            sample_stb <= 1'b1;
            tick       <= '0;
            dir_down   <= 1'b0;
         end else if (state == ST_PLAY) begin
            if (tick == div) begin
               tick <= '0;
               if (finish) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end else begin
                  idx        <= step_idx;
                  dir_down   <= step_dir;
                  r2r_out    <= rd_data;
                  sample_stb <= 1'b1;
               end
            end else begin
               tick <= tick + DIV_W'(1);
            end
         end
      end
   end

   assign busy = (state == ST_PLAY);

endmodule

// File: tb/tb_r2r_dac_wave_sequencer.sv
// Self-checking bench for r2r_dac_wave_sequencer: directed vector table,
// hand-written corner sequences and randomized playback against a model
// that derives the sample order from elapsed cycles after start.
module tb_r2r_dac_wave_sequencer;
   import r2r_pkg::*;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [3:0] r2r_out;
   logic       sample_stb, busy, done;
   logic [3:0] idx;

   always #50 clk = ~clk;

   r2r_dac_wave_sequencer_if bus ();

   r2r_dac_wave_sequencer dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .cmd        (bus),
      .r2r_out    (r2r_out),
      .sample_stb (sample_stb),
      .busy       (busy),
      .done       (done),
      .idx        (idx)
   );

   int tests = 0;
   int fails = 0;

   logic [3:0] m_mem [16];
   int         m_len, m_div, m_mode;
   logic [3:0] pre_r2r, pre_idx;

   typedef struct {
      logic [3:0]  len;
      logic [7:0]  div;
      logic [1:0]  mode;
      logic [47:0] seq;   // nibble c = expected idx (== r2r, mem[i]=i) at cycle c
      logic [11:0] stb;
      logic [11:0] bsy;
      logic [11:0] dn;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 4'd0;
      m_len = 15; m_div = 0; m_mode = 0;
   endtask

   // Sequencer view of cycle c after the start edge (c=0 is the first cycle).
   function automatic void model_at(input int c, output int e_idx, output bit e_stb,
                                    output bit e_busy, output bit e_done);
      int per, p, q, n;
      per = m_div + 1;
      p = c / per;
      e_stb = (c % per) == 0;
      e_busy = 1'b1;
      e_done = 1'b0;
      case (m_mode)
         1: e_idx = p % (m_len + 1);
         2: begin
            if (m_len == 0) e_idx = 0;
            else begin
               q = p % (2 * m_len);
               e_idx = (q <= m_len) ? q : 2 * m_len - q;
            end
         end
         default: begin
            n = (m_len + 1) * per;
            if (c < n) e_idx = p;
            else begin
               e_idx = m_len;
               e_stb = 1'b0;
               e_busy = 1'b0;
               e_done = (c == n);
            end
         end
      endcase
   endfunction

   task automatic send(input logic [1:0] op, input logic [7:0] arg);
      int n = 0;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_arg = arg;
      @(negedge clk);
      while (!bus.cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      pre_r2r = r2r_out;
      pre_idx = idx;
      if (!bus.cmd_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout: op %0d never accepted", op);
         #1 bus.cmd_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         bus.cmd_valid = 1'b0;
         case (op)
            OP_WRITE: m_mem[arg[7:4]] = arg[3:0];
            OP_LEN:   m_len = int'(arg[3:0]);
            OP_DIV:   m_div = int'(arg);
            default:  if (arg[0] && !arg[1]) m_mode = (arg[3:2] == 2'd3) ? 0 : int'(arg[3:2]);
         endcase
      end
   endtask

   task automatic run_check(input string name, input int ncyc);
      int ei; bit es, eb, ed;
      logic [10:0] act, exp;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         model_at(c, ei, es, eb, ed);
         act = {r2r_out, idx, sample_stb, busy, done};
         exp = {m_mem[ei], 4'(ei), es, eb, ed};
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc %0d: got r2r=%0d idx=%0d stb=%0b busy=%0b done=%0b expected r2r=%0d idx=%0d stb=%0b busy=%0b done=%0b",
                     name, c, act[10:7], act[6:3], act[2], act[1], act[0],
                     exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
         end
      end
   endtask

   initial begin
      logic [3:0] l; logic [7:0] d; logic [1:0] md; int nc;

      vecs[0] = '{len:4'd3, div:8'd1, mode:2'd0, seq:48'h333333221100, stb:12'h055, bsy:12'h0FF, dn:12'h100};
      vecs[1] = '{len:4'd3, div:8'd0, mode:2'd1, seq:48'h321032103210, stb:12'hFFF, bsy:12'hFFF, dn:12'h000};
      vecs[2] = '{len:4'd3, div:8'd0, mode:2'd2, seq:48'h123210123210, stb:12'hFFF, bsy:12'hFFF, dn:12'h000};
      vecs[3] = '{len:4'd0, div:8'd0, mode:2'd2, seq:48'h000000000000, stb:12'hFFF, bsy:12'hFFF, dn:12'h000};
      vecs[4] = '{len:4'd2, div:8'd2, mode:2'd3, seq:48'h222222111000, stb:12'h049, bsy:12'h1FF, dn:12'h200};
      vecs[5] = '{len:4'd1, div:8'd0, mode:2'd0, seq:48'h111111111110, stb:12'h003, bsy:12'h003, dn:12'h004};

      bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_arg = 8'd0;
      n_rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) n_rst = 1'b0;
      @(negedge clk);
      check("rst_r2r", int'(r2r_out), 0);
      check("rst_idx", int'(idx), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(bus.cmd_ready), 1);
      check("rst_stb", int'(sample_stb), 0);
      check("rst_done", int'(done), 0);

      for (int i = 0; i < 16; i++) send(OP_WRITE, {4'(i), 4'(i)});

      foreach (vecs[v]) begin
         send(OP_LEN, {4'd0, vecs[v].len});
         send(OP_DIV, vecs[v].div);
         send(OP_CTRL, {4'd0, vecs[v].mode, 2'b01});
         for (int c = 0; c < 12; c++) begin
            logic [10:0] act, exp;
            @(negedge clk);
            act = {r2r_out, idx, sample_stb, busy, done};
            exp = {vecs[v].seq[c*4 +: 4], vecs[v].seq[c*4 +: 4],
                   vecs[v].stb[c], vecs[v].bsy[c], vecs[v].dn[c]};
            tests++;
            if (act !== exp) begin
               fails++;
               $display("FAIL vec%0d cyc %0d: got %03h expected %03h ({r2r,idx,stb,busy,done})",
                        v, c, act, exp);
            end
         end
         send(OP_CTRL, 8'h02);
         @(negedge clk);
         check("vec_stopped_busy", int'(busy), 0);
      end

      // WRITE presented during PLAY stalls and leaves memory untouched.
      send(OP_LEN, 8'd3);
      send(OP_DIV, 8'd0);
      send(OP_CTRL, 8'b0000_0101);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_arg = 8'h1F;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("write_stall_ready", int'(bus.cmd_ready), 0);
      end
      @(posedge clk); #1 bus.cmd_valid = 1'b0;
      send(OP_CTRL, 8'h02);
      send(OP_LEN, 8'd1);
      send(OP_CTRL, 8'h01);
      run_check("write_stall_mem", 5);

      // Stop and start together: stop wins, outputs hold.
      send(OP_LEN, 8'd3);
      send(OP_DIV, 8'd1);
      send(OP_CTRL, 8'b0000_0101);
      repeat (5) @(negedge clk);
      send(OP_CTRL, 8'b0000_1011);
      @(negedge clk);
      check("stopstart_busy", int'(busy), 0);
      check("stopstart_r2r", int'(r2r_out), int'(pre_r2r));
      check("stopstart_idx", int'(idx), int'(pre_idx));
      check("stopstart_stb", int'(sample_stb), 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stopstart_hold", int'({r2r_out, done, sample_stb}), int'({pre_r2r, 2'b00}));
      end

      // Randomized playback against the model.
      for (int it = 0; it < 20; it++) begin
         for (int i = 0; i < 16; i++) send(OP_WRITE, {4'(i), 4'($urandom_range(0, 15))});
         l  = 4'($urandom_range(0, 15));
         d  = 8'($urandom_range(0, 3));
         md = 2'($urandom_range(0, 3));
         send(OP_LEN, {4'd0, l});
         send(OP_DIV, d);
         send(OP_CTRL, {4'd0, md, 2'b01});
         nc = (int'(l) + 1) * (int'(d) + 1) * 2 + 5;
         if (nc > 200) nc = 200;
         run_check("random", nc);
         send(OP_CTRL, 8'h02);
      end

      // Maximum divider: 256 cycles per sample.
      send(OP_WRITE, 8'h05);
      send(OP_WRITE, 8'h19);
      send(OP_LEN, 8'd1);
      send(OP_DIV, 8'd255);
      send(OP_CTRL, 8'h01);
      run_check("div255_oneshot", 516);

      // Restart during PLAY returns to index 0.
      send(OP_CTRL, 8'b0000_0101);
      run_check("restart_a", 300);
      send(OP_CTRL, 8'b0000_0101);
      run_check("restart_b", 4);

      // Asynchronous reset mid-playback.
      @(posedge clk); #20;
      n_rst = 1'b1;
      #1;
      check("midrst_r2r", int'(r2r_out), 0);
      check("midrst_idx", int'(idx), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_stb", int'(sample_stb), 0);
      check("midrst_done", int'(done), 0);
      model_reset();
      @(negedge clk) n_rst = 1'b0;
      send(OP_CTRL, 8'h01);
      run_check("post_rst_cleared", 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/r2r_dac_wave_sequencer.md
Name: r2r_dac_wave_sequencer

Overview:
- Pattern-playback controller for the 4-bit R2R DAC.
- Holds a small sample memory and a rate divider, programmed through a valid/ready command port.
- Steps the stored samples onto the DAC code bus in one-shot, loop or ping-pong order.
- Sits between the pin-level command interface and the R2R ladder, replacing free-running ramp generation with programmable waveforms.

Parameters:
- DEPTH, 16, number of pattern entries (index width IDX_W = 4)
- DATA_W, 4, DAC code width
- DIV_W, 8, sample-hold divider width

Ports:
- clk  in  1  system clock (10 MHz nominal)
- n_rst  in  1  reset, asynchronous, active-high (n_rst=1 resets the block)
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clk edge
- cmd_op  in  2  0=WRITE, 1=LEN, 2=DIV, 3=CTRL
- cmd_arg  in  8  WRITE: [7:4] addr, [3:0] sample; LEN: [3:0] last index; DIV: [7:0] divider; CTRL: [0] start, [1] stop, [3:2] mode
- r2r_out  out  4  DAC code to ladder, registered
- sample_stb  out  1  one-cycle pulse in the cycle r2r_out takes a new sample
- busy  out  1  high in PLAY
- done  out  1  one-cycle pulse on natural one-shot completion
- idx  out  4  index of sample currently on r2r_out

Behaviour:
- Reset values (async on n_rst=1): r2r_out=0, idx=0, busy=0, done=0, sample_stb=0, all memory entries=0, len=15, div=0, mode=0, dir=up, tick=0, state IDLE.
- cmd_ready:
  - IDLE: 1 for all ops.
  - PLAY: 1 only for cmd_op=3 (combinational on cmd_op); WRITE/LEN/DIV stall until IDLE.
- WRITE: mem[addr] <= sample. LEN: len <= arg[3:0]. DIV: div <= arg[7:0]. All take effect on the accepting edge.
- CTRL mode: 00 one-shot, 01 loop, 10 ping-pong, 11 treated as one-shot. Mode is latched only when start=1.
- CTRL with stop=1 takes priority over start; a stop received in IDLE is a no-op.
- FSM states: IDLE, PLAY.
- IDLE --start--> PLAY. On the edge after acceptance: idx=0, r2r_out=mem[0], sample_stb=1, tick=0, dir=up, busy=1.
- PLAY: tick increments every cycle. Each sample is held exactly div+1 cycles. At tick==div: tick<=0 and advance.
  - One-shot: idx==len -> IDLE, done=1 for one cycle, r2r_out holds the last sample, busy=0, no sample_stb. Otherwise idx+1.
  - Loop: idx==len -> idx=0, else idx+1.
  - Ping-pong: at idx==len while up, dir flips to down and idx-1. At idx==0 while down, dir flips to up and idx+1. Endpoints are not repeated. If len==0, idx stays 0 and a sample_stb pulse still occurs every div+1 cycles.
  - Each advance loads r2r_out=mem[new idx] and pulses sample_stb.
- Start accepted in PLAY restarts from idx 0 with the new mode (same timing as from IDLE). No done pulse.
- Stop accepted in PLAY: IDLE on the next edge, r2r_out and idx hold, no done, no sample_stb.
- Reset mid-playback: immediate return to reset values. The pattern memory is cleared.
- Width rules: tick is DIV_W bits and compared with ==, so div=255 gives 256 cycles/sample. idx arithmetic is mod 16 but never exceeds len.

Decomposition:
- Shared package r2r_pkg:
  - op encodings OP_WRITE/OP_LEN/OP_DIV/OP_CTRL
  - mode encodings MODE_ONESHOT/MODE_LOOP/MODE_PINGPONG
  - state enum IDLE/PLAY
  - DATA_W, IDX_W, DIV_W constants
- One sub-module r2r_pattern_mem: 16x4 register file with one sync write port, one async read port, async reset clear.
- The FSM, divider and index logic stay in the top module.

Test Plan:
- Reset then no commands -> r2r_out=0, busy=0, cmd_ready=1. Assert n_rst mid-PLAY -> all outputs return to 0 in the same cycle.
- WRITE mem[i]=i for i=0..3, LEN=3, DIV=1, CTRL start mode=00 -> r2r_out 0,0,1,1,2,2,3,3 with sample_stb every 2nd cycle; done pulses once; r2r_out stays 3; busy=0.
- Same pattern, DIV=0, mode=01 -> r2r_out 0,1,2,3,0,1,... sample_stb every cycle; done never asserts.
- LEN=3, DIV=0, mode=10 -> idx 0,1,2,3,2,1,0,1,2,...; LEN=0 mode=10 -> idx stays 0, sample_stb every cycle.
- In PLAY, present WRITE -> cmd_ready=0 and memory unchanged until stop. CTRL stop+start together -> stop wins, IDLE next edge, r2r_out held, no done.
- DIV=255, one-shot LEN=1 -> mem[0] held 256 cycles, then mem[1] held 256 cycles, then done. Start issued during PLAY -> idx returns to 0 on the next edge.
